// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: walks an LDM/STM register list and issues one register-file
// access plus one data-memory access per cycle. It supports IA/IB/DA/DB addressing
// and optional base writeback. A loaded R15 is routed to a dedicated PC-write strobe.
module ldm_stm_sequencer #(
    parameter int ADDR_STEP = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_l_bit,
    input  logic        i_p_bit,
    input  logic        i_u_bit,
    input  logic        i_w_bit,
    input  logic [3:0]  i_rn,
    input  logic [31:0] i_rn_val,
    input  logic [15:0] i_reglist,
    output logic [3:0]  o_rf_ra,
    input  logic [31:0] i_rf_rd,
    output logic        o_rf_we,
    output logic [3:0]  o_rf_wa,
    output logic [31:0] o_rf_wd,
    output logic        o_pc_we,
    output logic [31:0] o_pc_wd,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_mask;
    logic [31:0] r_addr;
    logic [31:0] r_wb_val;
    logic [3:0]  r_rn;
    logic        r_l;
    logic        r_wb_en;

    logic [4:0]  w_n;
    logic [31:0] w_span;
    logic [31:0] w_base;
    logic [31:0] w_start_addr;
    logic [31:0] w_wb_val;
    logic        w_wb_en;
    logic [3:0]  w_r;
    logic [15:0] w_mask_nxt;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    // Scanning downward leaves the lowest set bit as the final answer.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign w_n        = popcount16(i_reglist);
    assign w_span     = {27'd0, w_n} * STEP;
    assign w_base     = {i_rn_val[31:2], 2'b00};
    assign w_wb_val   = i_u_bit ? (i_rn_val + w_span) : (i_rn_val - w_span);
    assign w_wb_en    = i_w_bit && (i_rn != 4'd15) && !(i_l_bit && i_reglist[i_rn]);
    assign w_r        = lowest_idx(r_mask);
    assign w_mask_nxt = r_mask & (r_mask - 16'd1);

    // Lowest transfer address for the selected addressing mode.
    always_comb begin
        w_start_addr = w_base;
        case ({i_p_bit, i_u_bit})
            2'b01:   w_start_addr = w_base;
            2'b11:   w_start_addr = w_base + STEP;
            2'b00:   w_start_addr = w_base - w_span + STEP;
            default: w_start_addr = w_base - w_span;
        endcase
    end

    // State register plus the captured operation context and walking address/mask.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_mask   <= 16'd0;
            r_addr   <= 32'd0;
            r_wb_val <= 32'd0;
            r_rn     <= 4'd0;
            r_l      <= 1'b0;
            r_wb_en  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mask   <= i_reglist;
                        r_addr   <= w_start_addr;
                        r_wb_val <= w_wb_val;
                        r_rn     <= i_rn;
                        r_l      <= i_l_bit;
                        r_wb_en  <= w_wb_en;
                    end
                end
                S_XFER: begin
                    r_mask <= w_mask_nxt;
                    r_addr <= r_addr + STEP;
                end
                default: ;
            endcase
        end
    end

    // Next state and all outputs; everything is zero outside XFER/WB/DONE activity.
    always_comb begin
        w_state_nxt = r_state;
        o_rf_ra     = 4'd0;
        o_rf_we     = 1'b0;
        o_rf_wa     = 4'd0;
        o_rf_wd     = 32'd0;
        o_pc_we     = 1'b0;
        o_pc_wd     = 32'd0;
        o_mem_addr  = 32'd0;
        o_mem_we    = 1'b0;
        o_mem_wdata = 32'd0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (w_n != 5'd0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                o_busy     = 1'b1;
                o_mem_addr = r_addr;
                if (!r_l) begin
                    o_rf_ra     = w_r;
                    o_mem_we    = 1'b1;
                    o_mem_wdata = i_rf_rd;
                end else if (w_r == 4'd15) begin
                    o_pc_we = 1'b1;
                    o_pc_wd = i_mem_rdata;
                end else begin
                    o_rf_we = 1'b1;
                    o_rf_wa = w_r;
                    o_rf_wd = i_mem_rdata;
                end
                if (w_mask_nxt == 16'd0) begin
                    w_state_nxt = r_wb_en ? S_WB : S_DONE;
                end
            end
            S_WB: begin
                o_busy      = 1'b1;
                o_rf_we     = 1'b1;
                o_rf_wa     = r_rn;
                o_rf_wd     = r_wb_val;
                w_state_nxt = S_DONE;
            end
            default: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: cycle-by-cycle output checks at the falling edge.
module tb_ldm_stm_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        l_bit, p_bit, u_bit, w_bit;
    logic [3:0]  rn;
    logic [31:0] rn_val;
    logic [15:0] reglist;
    logic [3:0]  rf_ra;
    logic [31:0] rf_rd;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;

    int n_chk;
    int n_fail;

    ldm_stm_sequencer #(.ADDR_STEP(4)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_start     (start),
        .i_l_bit     (l_bit),
        .i_p_bit     (p_bit),
        .i_u_bit     (u_bit),
        .i_w_bit     (w_bit),
        .i_rn        (rn),
        .i_rn_val    (rn_val),
        .i_reglist   (reglist),
        .o_rf_ra     (rf_ra),
        .i_rf_rd     (rf_rd),
        .o_rf_we     (rf_we),
        .o_rf_wa     (rf_wa),
        .o_rf_wd     (rf_wd),
        .o_pc_we     (pc_we),
        .o_pc_wd     (pc_wd),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Register file and memory stand-ins: data is a fixed function of the address.
    assign rf_rd     = 32'hA000_0000 | {28'd0, rf_ra};
    assign mem_rdata = 32'h5A5A_0000 ^ mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic launch(input logic l, input logic p, input logic u, input logic w,
                          input logic [3:0] b, input logic [31:0] bv, input logic [15:0] rl);
        l_bit = l; p_bit = p; u_bit = u; w_bit = w;
        rn = b; rn_val = bv; reglist = rl;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_memwe"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_rfwe"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_pcwe"}, {31'd0, pc_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_rfwa"}, {28'd0, rf_wa}, 32'd0);
        chk({tag, "_rfra"}, {28'd0, rf_ra}, 32'd0);
    endtask

    task automatic chk_store(input string tag, input logic [3:0] r, input logic [31:0] a);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_memwe"}, {31'd0, mem_we}, 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_rfra"}, {28'd0, rf_ra}, {28'd0, r});
        chk({tag, "_wdata"}, mem_wdata, 32'hA000_0000 | {28'd0, r});
        chk({tag, "_rfwe"}, {31'd0, rf_we}, 32'd0);
    endtask

    task automatic chk_load(input string tag, input logic [3:0] r, input logic [31:0] a);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_memwe"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_rfwe"}, {31'd0, rf_we}, 32'd1);
        chk({tag, "_rfwa"}, {28'd0, rf_wa}, {28'd0, r});
        chk({tag, "_rfwd"}, rf_wd, 32'h5A5A_0000 ^ a);
        chk({tag, "_pcwe"}, {31'd0, pc_we}, 32'd0);
    endtask

    task automatic chk_wb(input string tag, input logic [3:0] r, input logic [31:0] v);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_rfwe"}, {31'd0, rf_we}, 32'd1);
        chk({tag, "_rfwa"}, {28'd0, rf_wa}, {28'd0, r});
        chk({tag, "_rfwd"}, rf_wd, v);
        chk({tag, "_memwe"}, {31'd0, mem_we}, 32'd0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rfwe"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_memwe"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_pcwe"}, {31'd0, pc_we}, 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset_n = 1'b0;
        start = 1'b0;
        l_bit = 1'b0; p_bit = 1'b0; u_bit = 1'b0; w_bit = 1'b0;
        rn = 4'd0; rn_val = 32'd0; reglist = 16'd0;
        cyc();
        cyc();
        chk_quiet("rst");
        reset_n = 1'b1;
        cyc();
        chk_quiet("idle");

        // STM IA R0-R3, base R13=0x100, writeback; context inputs scrambled after capture
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h000F);
        rn = 4'd7; rn_val = 32'hDEAD_BEE0; reglist = 16'hFFFF; l_bit = 1'b1; u_bit = 1'b0;
        chk_store("stmia1", 4'd0, 32'h100); cyc();
        chk_store("stmia2", 4'd1, 32'h104); cyc();
        chk_store("stmia3", 4'd2, 32'h108); cyc();
        chk_store("stmia4", 4'd3, 32'h10C); cyc();
        chk_wb("stmia_wb", 4'd13, 32'h110); cyc();
        chk_done("stmia_done"); cyc();
        chk_quiet("stmia_after");

        // LDM DB R0,R1,R15 from 0x200, no writeback
        launch(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h200, 16'h8003);
        chk_load("ldmdb1", 4'd0, 32'h1F4); cyc();
        chk_load("ldmdb2", 4'd1, 32'h1F8); cyc();
        chk("ldmdb3_pcwe", {31'd0, pc_we}, 32'd1);
        chk("ldmdb3_pcwd", pc_wd, 32'h5A5A_01FC);
        chk("ldmdb3_addr", mem_addr, 32'h1FC);
        chk("ldmdb3_rfwe", {31'd0, rf_we}, 32'd0);
        chk("ldmdb3_memwe", {31'd0, mem_we}, 32'd0);
        cyc();
        chk_done("ldmdb_done"); cyc();

        // LDM IA with base in the list: loaded value wins, no WB cycle
        launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 32'h300, 16'h0004);
        chk_load("ldmbase1", 4'd2, 32'h300); cyc();
        chk_done("ldmbase_done"); cyc();

        // Empty register list: done immediately, no strobes
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 32'h400, 16'h0000);
        chk_done("empty_done"); cyc();
        chk_quiet("empty_after");

        // Start held high while busy: the second request must be ignored
        l_bit = 1'b0; p_bit = 1'b0; u_bit = 1'b1; w_bit = 1'b0;
        rn = 4'd4; rn_val = 32'h500; reglist = 16'h0003;
        start = 1'b1;
        cyc();
        reglist = 16'hFFFF; rn_val = 32'h900;
        chk_store("hold1", 4'd0, 32'h500); cyc();
        chk_store("hold2", 4'd1, 32'h504); cyc();
        start = 1'b0;
        chk_done("hold_done"); cyc();
        chk_quiet("hold_after");

        // STM DA wrap down to 0x0
        launch(1'b0, 1'b0, 1'b0, 1'b0, 4'd6, 32'h4, 16'h0003);
        chk_store("stmda1", 4'd0, 32'h0); cyc();
        chk_store("stmda2", 4'd1, 32'h4); cyc();
        chk_done("stmda_done"); cyc();

        // STM IB at 0xFFFFFFFC wraps to 0x0; writeback also wraps to 0x0
        launch(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 32'hFFFF_FFFC, 16'h0001);
        chk_store("stmib1", 4'd0, 32'h0); cyc();
        chk_wb("stmib_wb", 4'd3, 32'h0); cyc();
        chk_done("stmib_done"); cyc();

        // Reset during the third transfer of a 5-register STM aborts cleanly
        launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 32'h1000, 16'h001F);
        chk_store("abort1", 4'd0, 32'h1000); cyc();
        chk_store("abort2", 4'd1, 32'h1004); cyc();
        chk_store("abort3", 4'd2, 32'h1008);
        reset_n = 1'b0;
        cyc();
        chk_quiet("abort_rst");
        reset_n = 1'b1;
        cyc();
        chk_quiet("abort_idle");
        cyc();
        chk_quiet("abort_idle2");

        // Fresh operation after the abort
        launch(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h40, 16'h0002);
        chk_load("post1", 4'd1, 32'h40); cyc();
        chk_done("post_done"); cyc();

        // Start and reset at the same edge: reset wins
        l_bit = 1'b0; p_bit = 1'b0; u_bit = 1'b1; w_bit = 1'b0;
        rn = 4'd0; rn_val = 32'h80; reglist = 16'h0001;
        start = 1'b1;
        reset_n = 1'b0;
        cyc();
        start = 1'b0;
        reset_n = 1'b1;
        chk_quiet("rst_vs_start");
        cyc();
        chk_quiet("rst_vs_start2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-cycle controller that executes ARM block-transfer instructions (LDM/STM) by walking a 16-bit register list and issuing one register-file access plus one data-memory access per cycle. It sits between the decoder and the three-ported register file / data memory, owning the register-file read port 2 address, the write port and the memory strobes while busy. Addressing modes IA/IB/DA/DB and base writeback are supported. The register file cannot write R15, so R15 loads are routed to a dedicated PC-write strobe.

## Interface
- ADDR_STEP, default 4: byte increment between consecutive transfers.

- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- l_bit  in  1  1 = load (LDM), 0 = store (STM).
- p_bit  in  1  pre-index (1) / post-index (0).
- u_bit  in  1  up (1) / down (0).
- w_bit  in  1  base writeback enable.
- rn  in  4  base register index.
- rn_val  in  32  base register value, captured at start.
- reglist  in  16  register list; bit i selects Ri.
- rf_ra  out  4  register-file read address for store data.
- rf_rd  in  32  register-file read data (R15 returns PC+8).
- rf_we  out  1  register-file write enable.
- rf_wa  out  4  register-file write address (never 15).
- rf_wd  out  32  register-file write data.
- pc_we  out  1  PC write strobe for a loaded R15.
- pc_wd  out  32  PC write data.
- mem_addr  out  32  data-memory byte address; [1:0] always 00.
- mem_we  out  1  data-memory write enable.
- mem_wdata  out  32  data-memory write data.
- mem_rdata  in  32  data-memory read data (combinational).
- busy  out  1  high in XFER and WB.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, XFER, WB, DONE. Start is ignored outside IDLE.
- In IDLE with start=1, capture reglist into a remaining mask, along with rn, rn_val, l/p/u/w. Compute n = popcount(reglist) as a 5-bit value.
- Start address, always the lowest address with rn_val[1:0] forced to 00:
  - IA: rn_val
  - IB: rn_val+4
  - DA: rn_val−4n+4
  - DB: rn_val−4n
- Writeback value is rn_val+4n when u=1, rn_val−4n when u=0. All arithmetic is mod 2^32.
- Next state after start:
  - XFER if n>0.
  - DONE if n=0: no transfers, no writeback.
- XFER cycle:
  - Select r = lowest set bit of the mask and drive mem_addr = current address.
  - Store: rf_ra=r, mem_we=1, mem_wdata=rf_rd.
  - Load with r≠15: rf_we=1, rf_wa=r, rf_wd=mem_rdata.
  - Load with r=15: pc_we=1, pc_wd=mem_rdata, rf_we=0.
  - At the edge: clear bit r and add 4 to the address.
  - When the mask becomes empty, go to WB if writeback is active, else DONE.
- Writeback is active only when w=1, rn≠15, and not (l=1 and reglist[rn]=1). In that last case the loaded value wins.
- WB cycle: rf_we=1, rf_wa=rn, rf_wd=writeback value, then go to DONE.
- DONE cycle: done=1, busy=0, then IDLE.
- Registers are always transferred in ascending index order, from lowest to highest address, for every mode.
- Strobes (rf_we, pc_we, mem_we) are combinational from state and are never asserted in IDLE or DONE.

## Timing
- start sampled at edge E0. Transfer k (1..n) occupies the cycle after E(k−1). WB, if active, follows at cycle n+1. done is high in the cycle after the last XFER/WB.
- Latency from start to done: n+1 cycles without writeback, n+2 with writeback, 1 with n=0.
- Throughput: one new operation every n+2 or n+3 cycles; start is accepted in the cycle after done at the earliest.
- Inputs other than rf_rd and mem_rdata are ignored after capture; changing them mid-operation has no effect.
- reset_n=0 at any edge forces IDLE, clears the mask, address and captured fields, and zeroes all registered state. All outputs are 0 in the following cycle, including an aborted operation; no partial writeback.
- Reset value of every output is 0, including rf_ra, rf_wa and mem_addr.
- start and reset_n asserted at the same edge: reset wins.

## Test plan
- STM IA, rn=13, rn_val=0x100, reglist=0x000F, w=1 → mem writes R0..R3 at 0x100/0x104/0x108/0x10C, then WB writes R13=0x110; done at cycle 6.
- LDM DB, rn_val=0x200, reglist=0x8003, w=0 → reads at 0x1F4 into R0, 0x1F8 into R1, 0x1FC as pc_we with pc_wd=mem_rdata; rf_we never targets 15; done at cycle 4.
- LDM IA with w=1, rn=2, reglist=0x0004 → R2 gets memory data; no WB cycle; done at cycle 2.
- reglist=0 with start → no strobes; done pulses at cycle 1. A start held during busy is ignored.
- DA wrap: rn_val=0x4, reglist=0x0003, u=0, p=0 → addresses 0x0 and 0x4; IB at rn_val=0xFFFFFFFC wraps to 0x0.
- reset_n low during the third XFER of a 5-register STM → no further mem_we; all outputs 0 next cycle; a new start afterwards behaves normally.
